// File: rtl/lane_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lane_ser_pkg
//  Purpose  : Shared types and helpers for the lane mask serializer.
//  Revision : 1.0 - initial release
// ============================================================================
package lane_ser_pkg;

  // Warp width of the default configuration.
  localparam int C_NUM_LANES_DEF = 32;

  // Lane-index width for a warp of n lanes. The result is never below 1,
  // so the index port never becomes zero-width.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_IDX_W = lane_idx_w(C_NUM_LANES_DEF);

  // Mask and index types for the default configuration. Instances built with
  // another warp width size their own vectors from NUM_LANES.
  typedef logic [C_NUM_LANES_DEF-1:0] lane_mask_t;
  typedef logic [LANE_IDX_W-1:0]      lane_idx_t;

  // Serializer state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ser_state_e;

endpackage : lane_ser_pkg
`default_nettype wire

// File: rtl/zero_counter.sv
`default_nettype none
// ============================================================================
//  Module   : zero_counter
//  Purpose  : Counts trailing (MODE=0) or leading (MODE=1) zeros of a vector.
//             An all-zero input reports count 0 and raises empty_o.
//  Revision : 1.0 - initial release
// ============================================================================
module zero_counter #(
  parameter  int WIDTH = 32,
  parameter  int MODE  = 0,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  if (MODE == 0) begin : g_trailing
    // Scan from the top down, so the lowest set bit is the last one written.
    always_comb begin
      count_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (data_i[i]) count_o = CNT_W'(i);
      end
    end
  end else begin : g_leading
    // Scan from the bottom up, so the highest set bit is the last one written.
    always_comb begin
      count_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|data_i;

endmodule : zero_counter
`default_nettype wire

// File: rtl/lane_mask_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_mask_serializer
//  Purpose  : Converts an active-lane mask plus tag into a stream of lane
//             indices, lowest active lane first, one beat per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_mask_serializer
  import lane_ser_pkg::*;
#(
  parameter int NUM_LANES = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_LANES-1:0]             in_mask_i,
  input  logic [TAG_WIDTH-1:0]             in_tag_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [lane_idx_w(NUM_LANES)-1:0] out_lane_o,
  output logic [TAG_WIDTH-1:0]             out_tag_o,
  output logic                             out_last_o,
  output logic                             busy_o
);

  localparam int C_IDX_W = lane_idx_w(NUM_LANES);

  if (NUM_LANES < 2) begin : g_param_check
    $fatal(1, "lane_mask_serializer: NUM_LANES must be at least 2");
  end

  ser_state_e               r_state;
  ser_state_e               w_state_nxt;
  logic [NUM_LANES-1:0]     r_mask;
  logic [NUM_LANES-1:0]     w_mask_nxt;
  logic [TAG_WIDTH-1:0]     r_tag;
  logic [TAG_WIDTH-1:0]     w_tag_nxt;

  logic [NUM_LANES-1:0]     w_mask_m1;
  logic [NUM_LANES-1:0]     w_mask_cleared;
  logic [C_IDX_W-1:0]       w_tzc;
  logic                     w_empty;
  logic                     w_last;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_in_nonzero;

  // Lowest set bit of the residual mask selects the current lane.
  zero_counter #(
    .WIDTH (NUM_LANES),
    .MODE  (0)
  ) u_tzc (
    .data_i  (r_mask),
    .count_o (w_tzc),
    .empty_o (w_empty)
  );

  // Subtracting one wraps at NUM_LANES bits; an empty mask only occurs in IDLE,
  // where the result is never used. ANDing with it clears the lowest set bit,
  // which is exactly the lane being delivered.
  assign w_mask_m1      = r_mask - {{(NUM_LANES-1){1'b0}}, 1'b1};
  assign w_mask_cleared = r_mask & w_mask_m1;
  assign w_last         = (w_mask_cleared == '0);
  assign w_in_nonzero   = |in_mask_i;

  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i;

  // Output decode; lane, tag and last are forced to zero outside ISSUE.
  // in_ready_o depends combinationally on out_ready_i during ISSUE so a new
  // request can be loaded on the final beat with no bubble.
  always_comb begin
    out_valid_o = 1'b0;
    out_lane_o  = '0;
    out_tag_o   = '0;
    out_last_o  = 1'b0;
    busy_o      = 1'b0;
    in_ready_o  = 1'b0;
    if (r_state == ISSUE) begin
      out_valid_o = 1'b1;
      out_lane_o  = w_tzc;
      out_tag_o   = r_tag;
      out_last_o  = w_last;
      busy_o      = 1'b1;
      in_ready_o  = ~flush_i & out_ready_i & w_last;
    end else begin
      in_ready_o  = ~flush_i;
    end
  end

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_tag_nxt   = r_tag;
    if (flush_i) begin
      w_state_nxt = IDLE;
      w_mask_nxt  = '0;
      w_tag_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A zero mask is accepted and dropped without producing a beat.
          if (w_in_fire && w_in_nonzero) begin
            w_state_nxt = ISSUE;
            w_mask_nxt  = in_mask_i;
            w_tag_nxt   = in_tag_i;
          end
        end
        ISSUE: begin
          if (w_out_fire) begin
            w_mask_nxt = w_mask_cleared;
            if (w_last) begin
              if (w_in_fire && w_in_nonzero) begin
                w_mask_nxt = in_mask_i;
                w_tag_nxt  = in_tag_i;
              end else begin
                w_state_nxt = IDLE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_mask_nxt  = '0;
          w_tag_nxt   = '0;
        end
      endcase
    end
  end

  // State, residual mask and tag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

`ifndef SYNTHESIS
  // A request in flight always has at least one lane left to deliver.
  a_issue_not_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (r_state == ISSUE) |-> !w_empty
  );
`endif

endmodule : lane_mask_serializer
`default_nettype wire

// File: tb/tb_lane_mask_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_mask_serializer
//  Purpose  : Directed vector bench for lane_mask_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_mask_serializer;

  localparam int NUM_LANES = 32;
  localparam int TAG_WIDTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_lane;
  logic [7:0]  out_tag;
  logic        out_last;
  logic        busy;

  int n_vec;
  int n_err;

  lane_mask_serializer #(
    .NUM_LANES (NUM_LANES),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_mask_i   (in_mask),
    .in_tag_i    (in_tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_lane_o  (out_lane),
    .out_tag_o   (out_tag),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] mask;
    logic [7:0]  tag;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_valid;
    logic [4:0]  e_lane;
    logic [7:0]  e_tag;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] m, logic [7:0] t,
                              logic ordy, logic eir, logic ev, logic [4:0] el,
                              logic [7:0] et, logic elast, logic eb);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.mask = m; v.tag = t; v.out_ready = ordy;
    v.e_in_ready = eir; v.e_valid = ev; v.e_lane = el; v.e_tag = et;
    v.e_last = elast; v.e_busy = eb;
    return v;
  endfunction

  // Compare every output against its expected value; one vector per call.
  task automatic check_all(string id, logic eir, logic ev, logic [4:0] el,
                           logic [7:0] et, logic elast, logic eb);
    n_vec++;
    if (in_ready !== eir) begin
      n_err++; $display("FAIL %s in_ready got %b want %b", id, in_ready, eir);
    end
    if (out_valid !== ev) begin
      n_err++; $display("FAIL %s out_valid got %b want %b", id, out_valid, ev);
    end
    if (out_lane !== el) begin
      n_err++; $display("FAIL %s out_lane got %0d want %0d", id, out_lane, el);
    end
    if (out_tag !== et) begin
      n_err++; $display("FAIL %s out_tag got %h want %h", id, out_tag, et);
    end
    if (out_last !== elast) begin
      n_err++; $display("FAIL %s out_last got %b want %b", id, out_last, elast);
    end
    if (busy !== eb) begin
      n_err++; $display("FAIL %s busy got %b want %b", id, busy, eb);
    end
  endtask

  task automatic drive(logic fl, logic iv, logic [31:0] m, logic [7:0] t, logic ordy);
    flush = fl; in_valid = iv; in_mask = m; in_tag = t; out_ready = ordy;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);

    // Columns: flush, in_valid, mask, tag, out_ready |
    //          in_ready, out_valid, lane, tag, last, busy
    // Basic request 0x13: lanes 0, 1, 4.
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,1,32'h0000_0013,8'hA5,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 0,1, 0,8'hA5,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 0,1, 1,8'hA5,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,1, 4,8'hA5,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Single top lane.
    vecs.push_back(mk(0,1,32'h8000_0000,8'h3C,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,1,31,8'h3C,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Backpressure on mask 0x6: lane 1 holds for three cycles.
    vecs.push_back(mk(0,1,32'h0000_0006,8'h11,0, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,0, 0,1, 1,8'h11,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,0, 0,1, 1,8'h11,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,0, 0,1, 1,8'h11,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 0,1, 1,8'h11,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,1, 2,8'h11,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Back-to-back A=0x1 then B=0x8; B waits while the last beat is stalled.
    vecs.push_back(mk(0,1,32'h0000_0001,8'hAA,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,1,32'h0000_0008,8'hBB,0, 0,1, 0,8'hAA,1,1));
    vecs.push_back(mk(0,1,32'h0000_0008,8'hBB,1, 1,1, 0,8'hAA,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,1, 3,8'hBB,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Back-to-back into a zero mask: request dropped, return to IDLE.
    vecs.push_back(mk(0,1,32'h0000_0002,8'h01,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,1,32'h0000_0000,8'h02,1, 1,1, 1,8'h01,1,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Zero mask in IDLE.
    vecs.push_back(mk(0,1,32'h0000_0000,8'h77,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Flush after lane 4 of mask 0xF0.
    vecs.push_back(mk(0,1,32'h0000_00F0,8'h5A,1, 1,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 0,1, 4,8'h5A,0,1));
    vecs.push_back(mk(1,0,32'h0,        8'h00,1, 0,1, 5,8'h5A,0,1));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));
    // Flush in IDLE blocks a concurrent request.
    vecs.push_back(mk(1,1,32'h0000_00FF,8'h99,1, 0,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,32'h0,        8'h00,1, 1,0, 0,8'h00,0,0));

    // Reset state while reset is held.
    #12;
    check_all("reset", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].mask, vecs[i].tag, vecs[i].out_ready);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_in_ready, vecs[i].e_valid,
                vecs[i].e_lane, vecs[i].e_tag, vecs[i].e_last, vecs[i].e_busy);
    end

    // Full warp: 32 beats, lanes 0..31, last only on 31.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 8'hC3, 1'b1);
    #1;
    check_all("full_accept", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    for (int l = 0; l < 32; l++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
      #1;
      check_all($sformatf("full_lane%0d", l), (l == 31), 1'b1, 5'(l), 8'hC3,
                (l == 31), 1'b1);
    end
    @(negedge clk);
    #1;
    check_all("full_done", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-request, between clock edges.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_00F0, 8'h5A, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    #1;
    check_all("rst_pre", 1'b0, 1'b1, 5'd4, 8'h5A, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_all($sformatf("rst_after%0d", k), 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_lane_mask_serializer
`default_nettype wire

// File: doc/lane_mask_serializer.md
Name: lane_mask_serializer

Overview:
- Takes a warp-level active-lane mask plus a tag and emits one lane index per cycle, lowest active lane first, through a valid/ready handshake.
- Sits between the issue stage and lane-serial consumers, e.g. divergent shared-memory and scalar-fallback paths.
- Uses a trailing-zero counter on the residual mask to find the next lane, then clears that bit on each accepted output beat.

Parameters:
- NUM_LANES, 32, number of lanes in a warp; must be >= 2 (elaboration-time fatal otherwise).
- TAG_WIDTH, 8, width of the opaque per-request tag carried to every output beat.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous abort; drops the request in flight.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when in_valid_i & in_ready_o.
- in_mask_i  input  NUM_LANES  active-lane mask; bit i = lane i.
- in_tag_i  input  TAG_WIDTH  request tag.
- out_valid_o  output  1  lane beat valid.
- out_ready_i  input  1  consumer ready.
- out_lane_o  output  $clog2(NUM_LANES)  index of the current lowest set bit of the residual mask.
- out_tag_o  output  TAG_WIDTH  tag of the request in flight.
- out_last_o  output  1  current beat is the final lane of the request.
- busy_o  output  1  a request is in flight (state ISSUE).

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE; mask_q='0; tag_q='0.
  - Outputs: out_valid_o=0, out_lane_o=0, out_tag_o=0, out_last_o=0, busy_o=0, in_ready_o=1.
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- State IDLE:
  - in_ready_o=1 and out_valid_o=0.
  - On in_fire with in_mask_i != 0: mask_q<=in_mask_i, tag_q<=in_tag_i, next state ISSUE.
  - On in_fire with in_mask_i == 0: request is consumed and silently dropped; state stays IDLE; no output beat.
- State ISSUE:
  - out_valid_o=1; out_lane_o=tzc(mask_q); out_tag_o=tag_q.
  - out_last_o = ((mask_q & (mask_q - 1)) == 0).
  - On out_fire: mask_q bit out_lane_o is cleared.
  - On out_fire & out_last_o with no in_fire: next state IDLE.
- Back-to-back requests:
  - In ISSUE, in_ready_o = out_fire & out_last_o. This combinational path from out_ready_i to in_ready_o is intentional.
  - An in_fire in that cycle loads the new mask and tag directly, giving zero bubble between requests.
  - If that new mask is zero: request dropped, next state IDLE.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_lane_o, out_tag_o and out_last_o hold stable (AXI-style; valid never retracts except on flush).
- Latency:
  - First beat appears the cycle after in_fire.
  - Throughput is one lane per cycle; a mask with N set bits takes N out_fire cycles.
- out_lane_o/out_last_o in IDLE: drive 0 (gated by state) to keep waveforms clean.
- flush_i:
  - Takes priority over everything: next state IDLE, mask_q<='0, tag_q<='0.
  - in_ready_o=0 during flush, so no request is accepted that cycle.
  - An out_fire coinciding with flush counts as delivered; flush takes effect on the next edge.
- Reset mid-request: the in-flight request is lost; no beats after reset deassertion.
- Width rules:
  - mask_q - 1 is computed at NUM_LANES bits and wraps harmlessly.
  - out_lane_o is zero-extended from the counter output.

Decomposition:
- Package lane_ser_pkg holds:
  - LANE_IDX_W = $clog2(NUM_LANES) as a function/localparam helper;
  - typedef lane_mask_t (logic [NUM_LANES-1:0]) and lane_idx_t;
  - state enum ser_state_e {IDLE, ISSUE}.
- One sub-module: instantiate the existing zero_counter in trailing mode (MODE=0, WIDTH=NUM_LANES) on mask_q. Its empty_o drives only an assertion: never empty in ISSUE.
- Registers and FSM live in lane_mask_serializer itself.

Test Plan:
1. Reset, then mask=32'h0000_0013, tag=8'hA5, out_ready_i=1. Expect:
   - out_lane_o = 0, 1, 4 on three consecutive cycles, all with tag A5;
   - out_last_o=1 only on lane 4;
   - busy_o low after that.
2. mask=32'h8000_0000 → single beat, lane 31, out_last_o=1. mask=32'hFFFF_FFFF → 32 beats, lanes 0..31, last on 31.
3. Backpressure: mask=32'h0000_0006, out_ready_i low for 3 cycles → lane 1 held stable with valid high. Then ready high → lanes 1, 2.
4. Back-to-back: request A mask=32'h1 then B mask=32'h8 with in_valid_i held → in_fire for B in the same cycle as A's last beat; B's lane 3 follows next cycle with no bubble.
5. Zero mask: in_mask_i=0 accepted in IDLE → in_ready_o stays 1, no out_valid_o, busy_o stays 0.
6. Flush/reset mid-request: mask=32'h0000_00F0, flush after lane 4 fires → next cycle out_valid_o=0 and IDLE. Repeat with rst_ni asserted asynchronously mid-cycle → outputs 0 immediately.
